// File: rtl/iscas_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : iscas_bist_ctrl
// Purpose  : LFSR-stimulus / MISR-compaction BIST controller for an ISCAS89
//            benchmark. Optional serial signature readout is enabled by
//            defining ISCAS_BIST_SIG_SHIFT_EN.
// Revision : 1.0  initial release
// ============================================================================
module iscas_bist_ctrl #(
    parameter int unsigned NPAT   = 255,
    parameter int unsigned WARM   = 8,
    parameter logic [7:0]  SEED   = 8'h01,
    parameter logic [15:0] GOLDEN = 16'h0000
) (
    input  logic        CK,
    input  logic        RN,
    input  logic        START,
    input  logic        RESP,
`ifdef ISCAS_BIST_SIG_SHIFT_EN
    input  logic        SHIFT,
    output logic        SO,
`endif
    output logic [3:0]  PAT,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [15:0] SIG
);

    // An all-zero seed would lock the LFSR, so it is replaced by 8'h01.
    localparam logic [7:0]  c_seed      = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [15:0] c_npat_last = 16'(NPAT - 1);
    localparam logic [15:0] c_warm_last = 16'(WARM - 1);
    localparam logic [15:0] c_poly      = 16'h1021;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WARM = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state, w_state_next;
    logic [7:0]  r_lfsr, w_lfsr_next, w_lfsr_step;
    logic [15:0] r_misr, w_misr_next, w_misr_step;
    logic [15:0] r_cnt, w_cnt_next;
    logic        r_pass, w_pass_next;
    logic [3:0]  r_pat;
    logic        r_busy, r_done;
    logic        w_active_next;

    assign w_lfsr_step = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_misr_step = {r_misr[14:0], 1'b0} ^ (r_misr[15] ? c_poly : 16'h0000)
                         ^ {15'd0, RESP};

    always_comb begin
        w_state_next = r_state;
        w_lfsr_next  = r_lfsr;
        w_misr_next  = r_misr;
        w_cnt_next   = r_cnt;
        w_pass_next  = r_pass;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    w_lfsr_next  = c_seed;
                    w_misr_next  = 16'h0000;
                    w_cnt_next   = 16'h0000;
                    w_state_next = (WARM == 0) ? S_RUN : S_WARM;
                end
`ifdef ISCAS_BIST_SIG_SHIFT_EN
                else if (r_state == S_DONE && SHIFT) begin
                    w_misr_next = {r_misr[14:0], 1'b0};
                end
`endif
            end
            S_WARM: begin
                w_lfsr_next = w_lfsr_step;
                if (r_cnt == c_warm_last) begin
                    w_cnt_next   = 16'h0000;
                    w_state_next = S_RUN;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            S_RUN: begin
                w_lfsr_next = w_lfsr_step;
                w_misr_next = w_misr_step;
                if (r_cnt == c_npat_last) begin
                    // Compare the signature that includes the final response.
                    w_pass_next  = (w_misr_step == GOLDEN);
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_active_next = (w_state_next == S_WARM) || (w_state_next == S_RUN);

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state <= S_IDLE;
            r_lfsr  <= c_seed;
            r_misr  <= 16'h0000;
            r_cnt   <= 16'h0000;
            r_pass  <= 1'b0;
            r_pat   <= 4'h0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_lfsr  <= w_lfsr_next;
            r_misr  <= w_misr_next;
            r_cnt   <= w_cnt_next;
            r_pass  <= w_pass_next;
            r_pat   <= w_active_next ? w_lfsr_next[3:0] : 4'h0;
            r_busy  <= w_active_next;
            r_done  <= (w_state_next == S_DONE);
        end
    end

`ifdef ISCAS_BIST_SIG_SHIFT_EN
    logic r_so;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_so <= 1'b0;
        end else begin
            r_so <= w_misr_next[15];
        end
    end

    assign SO = r_so;
`endif

    assign PAT  = r_pat;
    assign BUSY = r_busy;
    assign DONE = r_done;
    assign PASS = r_pass;
    assign SIG  = r_misr;

endmodule
`default_nettype wire

// File: tb/tb_iscas_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_iscas_bist_ctrl
// Purpose  : Self-checking bench for iscas_bist_ctrl using two instances
//            (with and without warm-up) and a sequence-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_iscas_bist_ctrl;

    localparam int          A_WARM = 3;
    localparam int          A_NPAT = 20;
    localparam logic [7:0]  A_SEED = 8'hA5;
    localparam logic [15:0] A_GOLD = 16'h0000;
    localparam int          B_WARM = 0;
    localparam int          B_NPAT = 7;
    localparam logic [7:0]  B_SEED = 8'h00;
    localparam logic [15:0] B_GOLD = 16'h1234;

    logic        clk = 1'b0;
    logic        rn;
    logic        start_a, start_b, resp_a, resp_b;
    logic [3:0]  pat_a, pat_b;
    logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [15:0] sig_a, sig_b;
    logic        sel;
    logic [3:0]  o_pat;
    logic        o_busy, o_done, o_pass;
    logic [15:0] o_sig;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] rb;

`ifdef ISCAS_BIST_SIG_SHIFT_EN
    logic so_a, so_b;
`endif

    always #5 clk = ~clk;

    iscas_bist_ctrl #(.NPAT(A_NPAT), .WARM(A_WARM), .SEED(A_SEED), .GOLDEN(A_GOLD)) u_dut_a (
        .CK(clk), .RN(rn), .START(start_a), .RESP(resp_a),
`ifdef ISCAS_BIST_SIG_SHIFT_EN
        .SHIFT(1'b0), .SO(so_a),
`endif
        .PAT(pat_a), .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .SIG(sig_a)
    );

    iscas_bist_ctrl #(.NPAT(B_NPAT), .WARM(B_WARM), .SEED(B_SEED), .GOLDEN(B_GOLD)) u_dut_b (
        .CK(clk), .RN(rn), .START(start_b), .RESP(resp_b),
`ifdef ISCAS_BIST_SIG_SHIFT_EN
        .SHIFT(1'b0), .SO(so_b),
`endif
        .PAT(pat_b), .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .SIG(sig_b)
    );

    always_comb begin
        o_pat  = sel ? pat_b  : pat_a;
        o_busy = sel ? busy_b : busy_a;
        o_done = sel ? done_b : done_a;
        o_pass = sel ? pass_b : pass_a;
        o_sig  = sel ? sig_b  : sig_a;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Feedback taps 7,5,4,3 expressed as a parity mask.
    function automatic logic [7:0] lfsr_nx(input logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    function automatic logic [15:0] misr_nx(input logic [15:0] m, input logic r);
        logic [15:0] t;
        t = {m[14:0], 1'b0};
        if (m[15]) t = t ^ 16'h1021;
        return t ^ {15'd0, r};
    endfunction

    task automatic drive(input bit s, input logic st, input logic rs);
        if (s) begin start_b = st; resp_b = rs; end
        else   begin start_a = st; resp_a = rs; end
    endtask

    // One full run on the selected instance; rbits[k] is the response held
    // during cycle k after the START edge.
    task automatic run(input bit s, input logic [63:0] rbits, input bit hold);
        int          w, n, total;
        logic [7:0]  l;
        logic [15:0] g, m;
        logic [3:0]  pats [64];
        w = s ? B_WARM : A_WARM;
        n = s ? B_NPAT : A_NPAT;
        g = s ? B_GOLD : A_GOLD;
        l = s ? B_SEED : A_SEED;
        if (l == 8'h00) l = 8'h01;
        total = w + n;
        for (int k = 0; k < total; k++) begin
            pats[k] = l[3:0];
            l = lfsr_nx(l);
        end
        m = 16'h0000;
        for (int k = w; k < total; k++) m = misr_nx(m, rbits[k]);

        sel = s;
        @(negedge clk);
        drive(s, 1'b1, 1'b0);
        @(negedge clk);
        for (int k = 0; k < total; k++) begin
            drive(s, hold, rbits[k]);
            chk($sformatf("pat_k%0d", k), {28'd0, o_pat}, {28'd0, pats[k]});
            chk("busy_run", {31'd0, o_busy}, 32'd1);
            chk("done_run", {31'd0, o_done}, 32'd0);
            @(negedge clk);
        end
        drive(s, 1'b0, 1'b0);
        chk("done_hi", {31'd0, o_done}, 32'd1);
        chk("busy_lo", {31'd0, o_busy}, 32'd0);
        chk("pat_done", {28'd0, o_pat}, 32'd0);
        chk("sig", {16'd0, o_sig}, {16'd0, m});
        chk("pass", {31'd0, o_pass}, {31'd0, (m == g)});
        @(negedge clk);
        chk("done_hold", {31'd0, o_done}, 32'd1);
        chk("sig_static", {16'd0, o_sig}, {16'd0, m});
    endtask

    initial begin
        rn = 1'b0; sel = 1'b0;
        start_a = 1'b0; start_b = 1'b0; resp_a = 1'b0; resp_b = 1'b0;
        @(negedge clk);
        chk("rst_pat_a",  {28'd0, pat_a},  32'd0);
        chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
        chk("rst_done_a", {31'd0, done_a}, 32'd0);
        chk("rst_pass_a", {31'd0, pass_a}, 32'd0);
        chk("rst_sig_a",  {16'd0, sig_a},  32'd0);
        chk("rst_pat_b",  {28'd0, pat_b},  32'd0);
        chk("rst_sig_b",  {16'd0, sig_b},  32'd0);
        rn = 1'b1;
        @(negedge clk);
        chk("idle_busy_a", {31'd0, busy_a}, 32'd0);
        chk("idle_done_b", {31'd0, done_b}, 32'd0);

        // No warm-up, zero seed, zero response against a nonzero golden value.
        run(1'b1, 64'd0, 1'b0);
        run(1'b1, {$urandom(), $urandom()}, 1'b0);

        // Warm-up instance: zero response, warm-only ones, single capture.
        run(1'b0, 64'd0, 1'b0);
        run(1'b0, (64'd1 << A_WARM) - 64'd1, 1'b0);
        run(1'b0, 64'd1 << A_WARM, 1'b0);
        run(1'b0, {$urandom(), $urandom()}, 1'b1);
        rb = {$urandom(), $urandom()};
        run(1'b0, rb, 1'b0);
        run(1'b0, rb, 1'b0);
        run(1'b0, 64'd0, 1'b0);

        // Asynchronous reset in the middle of RUN, after a passing run.
        sel = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; resp_a = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_busy", {31'd0, busy_a}, 32'd1);
        #2 rn = 1'b0;
        #1;
        chk("arst_pat",  {28'd0, pat_a},  32'd0);
        chk("arst_busy", {31'd0, busy_a}, 32'd0);
        chk("arst_done", {31'd0, done_a}, 32'd0);
        chk("arst_pass", {31'd0, pass_a}, 32'd0);
        chk("arst_sig",  {16'd0, sig_a},  32'd0);
        @(negedge clk);
        rn = 1'b1; resp_a = 1'b0;
        @(negedge clk);
        chk("post_busy", {31'd0, busy_a}, 32'd0);
        chk("post_done", {31'd0, done_a}, 32'd0);
        chk("post_pat",  {28'd0, pat_a},  32'd0);
        run(1'b0, {$urandom(), $urandom()}, 1'b0);
        run(1'b1, 64'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
